// File: rtl/demux1x8_deser.sv
// demux1x8_deser: 1:8 serial-to-parallel receiver with frame resync and optional idle timeout
module demux1x8_deser #(
   parameter bit LSB_FIRST = 1'b1,
   parameter int TIMEOUT   = 0,
   parameter int TO_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   input  logic       din,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       busy,
   output logic [2:0] cur_addr,
   output logic       frame_err
);
   typedef enum logic {IDLE, COLLECT} state_t;
   localparam logic [2:0] FA = LSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [2:0] LA = ~FA;
   state_t state, state_n;
   logic [7:0] shadow, shadow_n, wr, data_n;
   logic [2:0] wa, addr_n;
   logic [TO_W-1:0] to_cnt, to_n;
   logic collecting, abort, timed, complete, ov_n, fe_n;
   always_comb begin
      collecting = state == COLLECT;
      wa = start ? FA : cur_addr;
      wr = shadow;
      wr[wa] = din;
      complete = collecting && !start && cur_addr == LA;
      abort = collecting && start;
      timed = TIMEOUT != 0 && collecting && !in_valid && to_cnt + 1'b1 == TO_W'(TIMEOUT);
      state_n = state;
      shadow_n = shadow;
      data_n = out_data;
      addr_n = cur_addr;
      to_n = to_cnt;
      ov_n = 1'b0;
      fe_n = 1'b0;
      if (in_valid) begin
         // a start with a bit aborts the old frame and the bit opens a new one at FA
         shadow_n = wr;
         to_n = '0;
         fe_n = abort;
         ov_n = complete;
         data_n = complete ? wr : out_data;
         state_n = complete ? IDLE : COLLECT;
         addr_n = complete ? FA : (LSB_FIRST ? wa + 3'd1 : wa - 3'd1);
      end else if (abort || timed) begin
         fe_n = 1'b1;
         state_n = IDLE;
         addr_n = FA;
         to_n = '0;
      end else if (collecting) to_n = to_cnt + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shadow <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         cur_addr <= FA;
         to_cnt <= '0;
      end else begin
         state <= state_n;
         shadow <= shadow_n;
         out_data <= data_n;
         out_valid <= ov_n;
         frame_err <= fe_n;
         cur_addr <= addr_n;
         to_cnt <= to_n;
      end
   end
   assign busy = state == COLLECT;
endmodule

// File: tb/tb_demux1x8_deser.sv
// tb_demux1x8_deser: randomized self-checking bench over LSB-first, MSB-first and timeout variants
module tb_demux1x8_deser;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, din = 1'b0;
   logic [7:0] d_l, d_m, d_t;
   logic v_l, v_m, v_t, b_l, b_m, b_t, e_l, e_m, e_t;
   logic [2:0] a_l, a_m, a_t;
   int n_cmp = 0, n_err = 0, cyc = 0, ovl = 0;
   logic [7:0] ql[$], qm[$], qt[$];
   int cl[$];

   demux1x8_deser #(.LSB_FIRST(1'b1), .TIMEOUT(0), .TO_W(8)) u_l (.clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .din(din), .out_data(d_l), .out_valid(v_l), .busy(b_l), .cur_addr(a_l), .frame_err(e_l));
   demux1x8_deser #(.LSB_FIRST(1'b0), .TIMEOUT(0), .TO_W(8)) u_m (.clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .din(din), .out_data(d_m), .out_valid(v_m), .busy(b_m), .cur_addr(a_m), .frame_err(e_m));
   demux1x8_deser #(.LSB_FIRST(1'b1), .TIMEOUT(4), .TO_W(8)) u_t (.clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .din(din), .out_data(d_t), .out_valid(v_t), .busy(b_t), .cur_addr(a_t), .frame_err(e_t));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (v_l) begin ql.push_back(d_l); cl.push_back(cyc); end
      if (v_m) qm.push_back(d_m);
      if (v_t) qt.push_back(d_t);
      if ((v_l && e_l) || (v_m && e_m) || (v_t && e_t)) ovl <= ovl + 1;
   end

   // seq[i] is the i-th transmitted bit; the byte it forms depends only on bit order
   function automatic logic [7:0] pack(input logic [7:0] seq, input bit lsb);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[lsb ? i : 7 - i] = seq[i];
      return r;
   endfunction

   task automatic tick(input logic iv, input logic d, input logic st);
      in_valid = iv; din = d; start = st;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] seq, input int maxgap);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) repeat ($urandom_range(maxgap, 0)) tick(1'b0, 1'b0, 1'b0);
         tick(1'b1, seq[i], 1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(1'b0, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
      n_cmp++; if ({d_l, v_l, b_l, e_l, a_l} !== {8'h00, 3'b000, 3'd0}) begin n_err++; $display("FAIL reset_lsb got %h/%b%b%b/%0d exp 00/000/0", d_l, v_l, b_l, e_l, a_l); end
      n_cmp++; if ({d_m, v_m, b_m, e_m, a_m} !== {8'h00, 3'b000, 3'd7}) begin n_err++; $display("FAIL reset_msb got %h/%b%b%b/%0d exp 00/000/7", d_m, v_m, b_m, e_m, a_m); end
      n_cmp++; if ({d_t, v_t, b_t, e_t, a_t} !== {8'h00, 3'b000, 3'd0}) begin n_err++; $display("FAIL reset_to got %h/%b%b%b/%0d exp 00/000/0", d_t, v_t, b_t, e_t, a_t); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] seq = 8'h4D;
      for (int i = 0; i < 8; i++) begin
         tick(1'b1, seq[i], 1'b0);
         n_cmp++; if ({a_l, a_m} !== {3'(i + 1), 3'(6 - i)}) begin n_err++; $display("FAIL basic_addr bit %0d got %0d/%0d exp %0d/%0d", i, a_l, a_m, 3'(i + 1), 3'(6 - i)); end
         if (i < 7) begin
            n_cmp++; if ({v_l, v_m, b_l, b_m} !== 4'b0011) begin n_err++; $display("FAIL basic_mid bit %0d got v%b%b b%b%b exp v00 b11", i, v_l, v_m, b_l, b_m); end
         end
      end
      n_cmp++; if ({v_l, v_m, b_l, b_m} !== 4'b1100) begin n_err++; $display("FAIL basic_done got v%b%b b%b%b exp v11 b00", v_l, v_m, b_l, b_m); end
      n_cmp++; if ({d_l, d_m} !== {pack(seq, 1'b1), pack(seq, 1'b0)}) begin n_err++; $display("FAIL basic_data got %h/%h exp %h/%h", d_l, d_m, pack(seq, 1'b1), pack(seq, 1'b0)); end
      n_cmp++; if ({d_l, d_m} !== 16'h4DB2) begin n_err++; $display("FAIL basic_const got %h/%h exp 4d/b2", d_l, d_m); end
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++; if ({v_l, v_m, d_l} !== {2'b00, pack(seq, 1'b1)}) begin n_err++; $display("FAIL basic_hold got v%b%b %h exp v00 %h", v_l, v_m, d_l, pack(seq, 1'b1)); end
   endtask

   task automatic test_walking();
      int pos[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
      logic [7:0] seq;
      foreach (pos[k]) begin
         seq = 8'(1 << pos[k]);
         send(seq, 0);
         n_cmp++; if ({v_l, d_l, d_m} !== {1'b1, pack(seq, 1'b1), pack(seq, 1'b0)}) begin n_err++; $display("FAIL walk pos %0d got %b %h/%h exp 1 %h/%h", pos[k], v_l, d_l, d_m, pack(seq, 1'b1), pack(seq, 1'b0)); end
      end
   endtask

   task automatic test_gapped();
      logic [7:0] vals[2];
      vals[0] = 8'hA5; vals[1] = 8'($urandom);
      foreach (vals[f]) begin
         for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat ($urandom_range(3, 0)) tick(1'b0, 1'b0, 1'b0);
            tick(1'b1, vals[f][i], 1'b0);
            n_cmp++; if ({a_l, a_t, a_m} !== {3'(i + 1), 3'(i + 1), 3'(6 - i)}) begin n_err++; $display("FAIL gap_addr bit %0d got %0d/%0d/%0d exp %0d/%0d/%0d", i, a_l, a_t, a_m, 3'(i + 1), 3'(i + 1), 3'(6 - i)); end
         end
         n_cmp++; if ({v_l, v_t, e_t, d_l, d_t, d_m} !== {3'b110, vals[f], vals[f], pack(vals[f], 1'b0)}) begin n_err++; $display("FAIL gap_data got %b%b%b %h/%h/%h exp 110 %h", v_l, v_t, e_t, d_l, d_t, d_m, vals[f]); end
      end
   endtask

   task automatic test_abort();
      logic [7:0] x = 8'($urandom);
      send(x, 0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom), 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      n_cmp++; if ({e_l, e_m, e_t, b_l, b_m, b_t, v_l} !== 7'b1110000) begin n_err++; $display("FAIL abort_flags got e%b%b%b b%b%b%b v%b exp e111 b000 v0", e_l, e_m, e_t, b_l, b_m, b_t, v_l); end
      n_cmp++; if ({d_l, d_m, a_l, a_m} !== {x, pack(x, 1'b0), 3'd0, 3'd7}) begin n_err++; $display("FAIL abort_hold got %h/%h %0d/%0d exp %h/%h 0/7", d_l, d_m, a_l, a_m, x, pack(x, 1'b0)); end
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++; if ({e_l, e_m, e_t} !== 3'b000) begin n_err++; $display("FAIL abort_pulse got %b%b%b exp 000", e_l, e_m, e_t); end
   endtask

   task automatic test_timeout();
      logic [7:0] seq = 8'h3C;
      do_reset();
      for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom), 1'b0);
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 1'b0, 1'b0);
         n_cmp++; if ({e_t, b_t, e_l, b_l} !== {k == 4, k < 4, 2'b01}) begin n_err++; $display("FAIL timeout idle %0d got e%b b%b lsb e%b b%b exp e%b b%b lsb e0 b1", k, e_t, b_t, e_l, b_l, k == 4, k < 4); end
      end
      n_cmp++; if ({a_t, d_t} !== {3'd0, 8'h00}) begin n_err++; $display("FAIL timeout_state got %0d %h exp 0 00", a_t, d_t); end
      tick(1'b1, seq[0], 1'b1);
      n_cmp++; if ({e_t, e_l, e_m, b_t, b_l, a_t, a_l} !== {3'b011, 2'b11, 3'd1, 3'd1}) begin n_err++; $display("FAIL restart got e%b%b%b b%b%b a%0d/%0d exp e011 b11 a1/1", e_t, e_l, e_m, b_t, b_l, a_t, a_l); end
      for (int i = 1; i < 8; i++) tick(1'b1, seq[i], 1'b0);
      n_cmp++; if ({v_t, v_l, d_t, d_l, d_m} !== {2'b11, 8'h3C, 8'h3C, pack(seq, 1'b0)}) begin n_err++; $display("FAIL after_timeout got %b%b %h/%h/%h exp 11 3c/3c/%h", v_t, v_l, d_t, d_l, d_m, pack(seq, 1'b0)); end
   endtask

   task automatic test_rst_mid();
      send(8'h96, 0);
      for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom), 1'b0);
      rst = 1'b1; tick(1'b0, 1'b0, 1'b0); rst = 1'b0;
      n_cmp++; if ({e_l, e_m, b_l, a_l, a_m, d_l, d_m} !== {3'b000, 3'd0, 3'd7, 16'h0000}) begin n_err++; $display("FAIL rst_mid got e%b%b b%b a%0d/%0d %h/%h exp e00 b0 a0/7 00/00", e_l, e_m, b_l, a_l, a_m, d_l, d_m); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals[6];
      logic [7:0] seq;
      int bl, bm, nb;
      vals[0] = 8'h11; vals[1] = 8'hEE; vals[2] = 8'h7F;
      for (int k = 3; k < 6; k++) vals[k] = 8'($urandom);
      do_reset();
      bl = ql.size(); bm = qm.size();
      foreach (vals[k]) send(vals[k], 0);
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++; if (ql.size() - bl !== 6) begin n_err++; $display("FAIL stream_count got %0d exp 6", ql.size() - bl); end
      else foreach (vals[k]) begin
         n_cmp++; if ({ql[bl + k], qm[bm + k]} !== {vals[k], pack(vals[k], 1'b0)}) begin n_err++; $display("FAIL stream_data %0d got %h/%h exp %h/%h", k, ql[bl + k], qm[bm + k], vals[k], pack(vals[k], 1'b0)); end
         if (k > 0) begin
            n_cmp++; if (cl[bl + k] - cl[bl + k - 1] !== 8) begin n_err++; $display("FAIL stream_spacing %0d got %0d exp 8", k, cl[bl + k] - cl[bl + k - 1]); end
         end
      end
      for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom), 1'b0);
      seq = 8'($urandom);
      tick(1'b1, seq[0], 1'b1);
      n_cmp++; if ({e_l, e_m, v_l, a_l, a_m} !== {3'b110, 3'd1, 3'd6}) begin n_err++; $display("FAIL stream_restart got e%b%b v%b a%0d/%0d exp e11 v0 a1/6", e_l, e_m, v_l, a_l, a_m); end
      for (int i = 1; i < 8; i++) tick(1'b1, seq[i], 1'b0);
      n_cmp++; if ({v_l, d_l, d_m} !== {1'b1, seq, pack(seq, 1'b0)}) begin n_err++; $display("FAIL stream_newframe got %b %h/%h exp 1 %h/%h", v_l, d_l, d_m, seq, pack(seq, 1'b0)); end
   endtask

   task automatic test_random();
      logic [7:0] exp[$];
      int bl, bm, bt;
      do_reset();
      bl = ql.size(); bm = qm.size(); bt = qt.size();
      for (int f = 0; f < 20; f++) begin
         exp.push_back(8'($urandom));
         send(exp[f], 3);
         repeat ($urandom_range(2, 0)) tick(1'b0, 1'b0, 1'b0);
      end
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++; if ({ql.size() - bl, qm.size() - bm, qt.size() - bt} !== {32'd20, 32'd20, 32'd20}) begin n_err++; $display("FAIL random_count got %0d/%0d/%0d exp 20", ql.size() - bl, qm.size() - bm, qt.size() - bt); end
      else foreach (exp[f]) begin
         n_cmp++; if ({ql[bl + f], qm[bm + f], qt[bt + f]} !== {exp[f], pack(exp[f], 1'b0), exp[f]}) begin n_err++; $display("FAIL random_data %0d got %h/%h/%h exp %h/%h/%h", f, ql[bl + f], qm[bm + f], qt[bt + f], exp[f], pack(exp[f], 1'b0), exp[f]); end
      end
   endtask

   task automatic test_exclusive();
      n_cmp++; if (ovl !== 0) begin n_err++; $display("FAIL valid_err_overlap got %0d cycles exp 0", ovl); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_walking();
      test_gapped();
      test_abort();
      test_timeout();
      test_rst_mid();
      test_back_to_back();
      test_random();
      test_exclusive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
